// File: rtl/pq_access_arbiter.sv
// pq_access_arbiter
//
// Sits between NUM_REQ producers and an external priority queue.
//
// Enqueue side:
//   - A round-robin search over req_valid picks one producer per cycle.
//   - That producer's payload is tagged with its index and written to the queue.
//   - Any set valid bit enqueues the same cycle, as long as the queue is not full.
//
// Drain side:
//   - A three-state FSM (EMPTY / FETCH / VALID) pops the queue.
//   - It accounts for the queue's one-cycle registered read latency.
//   - It holds the popped entry on out_* until the consumer takes it.
//
// Ports:
//   clk, rst_n                  clock (rising edge); asynchronous active-low reset
//   req_valid/req_data/
//     req_priority              per-producer entry, payload and priority (slice i)
//   req_ready                   one-hot accept strobe back to producers
//   pq_wdata/pq_wpriority/
//     pq_enqueue, pq_full       queue write side
//   pq_dequeue, pq_rdata/
//     pq_rpriority, pq_empty    queue read side (data valid one cycle after dequeue)
//   out_valid/out_ready/
//     out_data/out_priority/
//     out_src                   drained entry to the consumer
module pq_access_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int DATA_WIDTH     = 8,
   parameter int PRIORITY_WIDTH = 3,
   parameter int SRC_WIDTH      = $clog2(NUM_REQ),
   parameter int PQ_WIDTH       = SRC_WIDTH + DATA_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ*PRIORITY_WIDTH-1:0] req_priority,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [PQ_WIDTH-1:0]           pq_wdata,
   output logic [PRIORITY_WIDTH-1:0]     pq_wpriority,
   output logic                          pq_enqueue,
   input  logic                          pq_full,
   output logic                          pq_dequeue,
   input  logic [PQ_WIDTH-1:0]           pq_rdata,
   input  logic [PRIORITY_WIDTH-1:0]     pq_rpriority,
   input  logic                          pq_empty,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic [PRIORITY_WIDTH-1:0]     out_priority,
   output logic [SRC_WIDTH-1:0]          out_src
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FETCH = 2'd1,
      VALID = 2'd2
   } drain_state_t;

   // ------------------------------------------------------------------
   // Enqueue side
   // ------------------------------------------------------------------
   logic [SRC_WIDTH-1:0]      rr_ptr_reg;
   logic [SRC_WIDTH-1:0]      grant_idx;
   logic [SRC_WIDTH-1:0]      scan_idx;
   logic                      grant_found;
   logic [DATA_WIDTH-1:0]     data_arr [NUM_REQ];
   logic [PRIORITY_WIDTH-1:0] prio_arr [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign data_arr[gi]  = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
         assign prio_arr[gi]  = req_priority[gi*PRIORITY_WIDTH +: PRIORITY_WIDTH];
         assign req_ready[gi] = pq_enqueue && (grant_idx == SRC_WIDTH'(gi));
      end
   endgenerate

   // Search upward from rr_ptr.
   // NUM_REQ is a power of two, so the SRC_WIDTH-bit add wraps for free.
   always_comb begin
      grant_idx   = '0;
      grant_found = 1'b0;
      scan_idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = rr_ptr_reg + SRC_WIDTH'(k);
         if (!grant_found && req_valid[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx;
         end
      end
   end

   // Gating with rst_n keeps every strobe low while reset is held, not
   // just after the first clock edge of reset.
   assign pq_enqueue   = rst_n && grant_found && !pq_full;
   assign pq_wdata     = pq_enqueue ? {grant_idx, data_arr[grant_idx]} : '0;
   assign pq_wpriority = pq_enqueue ? prio_arr[grant_idx] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_reg <= '0;
      end else if (pq_enqueue) begin
         rr_ptr_reg <= grant_idx + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Drain side
   // ------------------------------------------------------------------
   drain_state_t              state_reg, state_next;
   logic                      dequeue_next;
   logic [DATA_WIDTH-1:0]     out_data_reg;
   logic [PRIORITY_WIDTH-1:0] out_priority_reg;
   logic [SRC_WIDTH-1:0]      out_src_reg;

   always_comb begin
      state_next   = state_reg;
      dequeue_next = 1'b0;
      case (state_reg)
         EMPTY: begin
            if (!pq_empty) begin
               dequeue_next = 1'b1;
               state_next   = FETCH;
            end
         end
         // Queue output becomes valid this cycle; the registers below capture it.
         FETCH: begin
            state_next = VALID;
         end
         VALID: begin
            if (out_ready) begin
               if (!pq_empty) begin
                  dequeue_next = 1'b1;
                  state_next   = FETCH;
               end else begin
                  state_next = EMPTY;
               end
            end
         end
         default: begin
            state_next = EMPTY;
         end
      endcase
   end

   assign pq_dequeue = rst_n && dequeue_next;
   assign out_valid  = (state_reg == VALID);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= EMPTY;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_reg     <= '0;
         out_priority_reg <= '0;
         out_src_reg      <= '0;
      end else if (state_reg == FETCH) begin
         out_data_reg     <= pq_rdata[DATA_WIDTH-1:0];
         out_src_reg      <= pq_rdata[PQ_WIDTH-1:DATA_WIDTH];
         out_priority_reg <= pq_rpriority;
      end
   end

   assign out_data     = out_data_reg;
   assign out_priority = out_priority_reg;
   assign out_src      = out_src_reg;

endmodule
